// File: rtl/weight_row_loader_if.sv
// Serial weight beat stream from the weight FIFO buffer (data_out / out_vld).
//   w_in  : one weight per beat
//   w_vld : beat valid; the stream has no backpressure
// master drives the stream (FIFO side), slave consumes it (row loader side).
interface weight_row_loader_if #(
    parameter int unsigned data_width = 16
);
    logic [data_width-1:0] w_in;
    logic                  w_vld;

    modport master (output w_in, output w_vld);
    modport slave  (input  w_in, input  w_vld);
endinterface

// File: rtl/weight_row_loader.sv
// Collects a column of weight_dim serial weights into a parallel row bank, then pulses w_load
// once so the systolic array latches every row together. The column stays in w_out until the
// next accepted start.
//   clk, nrst  : rising-edge clock, asynchronous active-low reset
//   start      : begin a new column; weight_dim is sampled with it
//   weight_dim : column length, legal range 1..array_dim
//   wbus       : serial weight stream (slave side)
//   w_out      : row bank, row r at [r*data_width +: data_width]
//   w_load     : single-cycle latch strobe for the PEs
//   busy/done  : collecting-or-loading / column held and stable
//   ovf        : sticky error, stray beat or illegal weight_dim
module weight_row_loader #(
    parameter int unsigned data_width = 16,
    parameter int unsigned array_dim  = 14
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            start,
    input  logic [4:0]                      weight_dim,
    weight_row_loader_if.slave              wbus,
    output logic [array_dim*data_width-1:0] w_out,
    output logic                            w_load,
    output logic                            busy,
    output logic                            done,
    output logic                            ovf
);

    localparam logic [4:0] DimMax = 5'(array_dim);

    typedef enum logic [1:0] {StIdle, StFill, StLoad, StHold} state_e;

    state_e                            state_q, state_d;
    logic [4:0]                        cnt_q, cnt_d;
    logic [4:0]                        dim_q, dim_d;
    logic [array_dim*data_width-1:0]   w_out_q, w_out_d;
    logic                              ovf_q, ovf_d;
    logic                              w_load_q, busy_q, done_q;

    logic dim_ok;
    logic accept;

    assign dim_ok = (weight_dim != 5'd0) && (weight_dim <= DimMax);
    // A start is honoured everywhere except during the one-cycle LOAD strobe.
    assign accept = start && dim_ok && (state_q != StLoad);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dim_d   = dim_q;
        w_out_d = w_out_q;
        ovf_d   = ovf_q;

        if (start && !dim_ok) begin
            ovf_d = 1'b1;
        end

        if (accept) begin
            // Accepted start wins over any beat in the same cycle; that beat is dropped silently.
            dim_d   = weight_dim;
            cnt_d   = 5'd0;
            w_out_d = '0;
            ovf_d   = 1'b0;
            state_d = StFill;
        end else begin
            case (state_q)
                StFill: begin
                    if (wbus.w_vld) begin
                        for (int r = 0; r < int'(array_dim); r++) begin
                            if (cnt_q == 5'(r)) begin
                                w_out_d[r*data_width +: data_width] = wbus.w_in;
                            end
                        end
                        // cnt parks at dim-1 on the last beat instead of wrapping.
                        if (cnt_q == dim_q - 5'd1) begin
                            state_d = StLoad;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                StLoad: begin
                    state_d = StHold;
                    if (wbus.w_vld) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    if (wbus.w_vld) begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            dim_q    <= 5'd0;
            w_out_q  <= '0;
            ovf_q    <= 1'b0;
            w_load_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dim_q    <= dim_d;
            w_out_q  <= w_out_d;
            ovf_q    <= ovf_d;
            // Status flags are registered copies of the current state, so they trail the state
            // register by one cycle: last beat -> LOAD, then w_load, then done.
            w_load_q <= (state_q == StLoad);
            busy_q   <= (state_q == StFill) || (state_q == StLoad);
            done_q   <= (state_q == StHold);
        end
    end

    assign w_out  = w_out_q;
    assign w_load = w_load_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_weight_row_loader.sv
module tb_weight_row_loader;

    localparam int DW = 16;
    localparam int AD = 14;
    localparam int WW = AD * DW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic [4:0]    weight_dim;
    logic [WW-1:0] w_out;
    logic          w_load, busy, done, ovf;

    int checks   = 0;
    int failures = 0;

    weight_row_loader_if #(.data_width(DW)) wbus ();

    weight_row_loader #(
        .data_width(DW),
        .array_dim (AD)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .weight_dim(weight_dim),
        .wbus      (wbus),
        .w_out     (w_out),
        .w_load    (w_load),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        start;
        logic [4:0]  wdim;
        logic        vld;
        logic [15:0] win;
        logic        busy;
        logic        done;
        logic        load;
        logic        ovf;
        int          row;
        logic [15:0] rowv;
        bit          full;
        int          full_n;
        logic [15:0] full_base;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic s, logic [4:0] d, logic v, logic [15:0] w,
                                logic b, logic dn, logic ld, logic o, int row = -1,
                                logic [15:0] rv = 16'h0, bit full = 1'b0, int fn = 0,
                                logic [15:0] fb = 16'h0);
        vec_t x;
        x.name = nm; x.start = s; x.wdim = d; x.vld = v; x.win = w;
        x.busy = b; x.done = dn; x.load = ld; x.ovf = o;
        x.row = row; x.rowv = rv; x.full = full; x.full_n = fn; x.full_base = fb;
        vecs.push_back(x);
    endfunction

    // Expected bank: rows 0..n-1 hold base+r, all others zero.
    function automatic logic [WW-1:0] bank(int n, logic [15:0] base);
        logic [WW-1:0] b = '0;
        for (int r = 0; r < n; r++) b[r*DW +: DW] = base + 16'(r);
        return b;
    endfunction

    task automatic check(string nm, logic [WW-1:0] got, logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_flags(string nm, logic b, logic dn, logic ld, logic o);
        check({nm, "_busy"}, WW'(busy), WW'(b));
        check({nm, "_done"}, WW'(done), WW'(dn));
        check({nm, "_load"}, WW'(w_load), WW'(ld));
        check({nm, "_ovf"}, WW'(ovf), WW'(o));
    endtask

    task automatic idle_inputs();
        start = 1'b0; weight_dim = 5'd0; wbus.w_vld = 1'b0; wbus.w_in = 16'h0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        idle_inputs();
        step();
        step();
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_wout", w_out, '0);
        nrst = 1'b1;
    endtask

    initial begin
        // Illegal weight_dim values, then a 3-deep column.
        add("t3_dim0",  1, 5'd0,  0, 16'h0, 0, 0, 0, 1, -1, 0, 1, 0, 0);
        add("t3_dim15", 1, 5'd15, 0, 16'h0, 0, 0, 0, 1, -1, 0, 1, 0, 0);
        add("t3_idle",  0, 5'd0,  0, 16'h0, 0, 0, 0, 1, -1, 0, 1, 0, 0);
        add("t1_start", 1, 5'd3,  0, 16'h0, 0, 0, 0, 0, -1, 0, 1, 0, 0);
        add("t1_b0",    0, 5'd0,  1, 16'h1, 1, 0, 0, 0, 0, 16'h1);
        add("t1_b1",    0, 5'd0,  1, 16'h2, 1, 0, 0, 0, 1, 16'h2);
        add("t1_b2",    0, 5'd0,  1, 16'h3, 1, 0, 0, 0, 2, 16'h3);
        add("t1_load",  0, 5'd0,  0, 16'h0, 1, 0, 1, 0);
        add("t1_done",  0, 5'd0,  0, 16'h0, 0, 1, 0, 0, -1, 0, 1, 3, 16'h1);
        add("t1_hold",  0, 5'd0,  0, 16'h0, 0, 1, 0, 0, -1, 0, 1, 3, 16'h1);
        // Full 14-deep column with a gap after every beat, started from HOLD.
        add("t2_start", 1, 5'd14, 0, 16'h0, 0, 1, 0, 0, -1, 0, 1, 0, 0);
        for (int k = 0; k < AD; k++) begin
            add($sformatf("t2_beat%0d", k), 0, 5'd0, 1, 16'h10 + 16'(k), 1, 0, 0, 0,
                k, 16'h10 + 16'(k));
            if (k < AD - 1) begin
                add($sformatf("t2_gap%0d", k), 0, 5'd0, 0, 16'h0, 1, 0, 0, 0,
                    k, 16'h10 + 16'(k));
            end
        end
        add("t2_load",  0, 5'd0,  0, 16'h0, 1, 0, 1, 0);
        add("t2_done",  0, 5'd0,  0, 16'h0, 0, 1, 0, 0, -1, 0, 1, 14, 16'h10);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("v%0d_%s", i, vecs[i].name);
            start = vecs[i].start;
            weight_dim = vecs[i].wdim;
            wbus.w_vld = vecs[i].vld;
            wbus.w_in = vecs[i].win;
            step();
            check_flags(nm, vecs[i].busy, vecs[i].done, vecs[i].load, vecs[i].ovf);
            if (vecs[i].row >= 0)
                check({nm, "_row"}, WW'(w_out[vecs[i].row*DW +: DW]), WW'(vecs[i].rowv));
            if (vecs[i].full)
                check({nm, "_wout"}, w_out, bank(vecs[i].full_n, vecs[i].full_base));
        end
        idle_inputs();

        // Stray beat while holding a column.
        wbus.w_vld = 1'b1; wbus.w_in = 16'hBEEF;
        step();
        wbus.w_vld = 1'b0;
        check_flags("t4_stray", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_wout", w_out, bank(14, 16'h10));
        step();
        check_flags("t4_sticky", 1'b0, 1'b1, 1'b0, 1'b1);

        // Valid start clears ovf and the bank; then restart mid-fill.
        start = 1'b1; weight_dim = 5'd4;
        step();
        start = 1'b0;
        check_flags("t5_start", 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_clear", w_out, '0);
        step();
        check_flags("t5_fill", 1'b1, 1'b0, 1'b0, 1'b0);
        wbus.w_vld = 1'b1; wbus.w_in = 16'h5;
        step();
        wbus.w_in = 16'h6;
        step();
        check("t5_two_beats", w_out, bank(2, 16'h5));
        start = 1'b1; weight_dim = 5'd2; wbus.w_in = 16'h7777;
        step();
        start = 1'b0;
        check("t5_restart_wout", w_out, '0);
        check_flags("t5_restart", 1'b1, 1'b0, 1'b0, 1'b0);
        wbus.w_in = 16'hA;
        step();
        check_flags("t5_b0", 1'b1, 1'b0, 1'b0, 1'b0);
        wbus.w_in = 16'hB;
        step();
        wbus.w_vld = 1'b0;
        check_flags("t5_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_flags("t5_load", 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_wout", w_out, bank(2, 16'hA));
        step();
        check_flags("t5_done", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fill.
        start = 1'b1; weight_dim = 5'd3;
        step();
        start = 1'b0;
        wbus.w_vld = 1'b1; wbus.w_in = 16'h42;
        step();
        wbus.w_vld = 1'b0;
        check_flags("t6_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_pre_row0", WW'(w_out[0 +: DW]), WW'(16'h42));
        #2 nrst = 1'b0;
        #1;
        check_flags("t6_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_async_wout", w_out, '0);
        @(negedge clk);
        nrst = 1'b1;
        wbus.w_vld = 1'b1; wbus.w_in = 16'h99;
        step();
        wbus.w_vld = 1'b0;
        check_flags("t6_after", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_after_wout", w_out, '0);
        step();
        check_flags("t6_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
